pulse_scheduler: RTL and testbench

PULSE_SCHEDULER -- requirements
Module: pulse_scheduler

---
 rtl/pulse_scheduler_pkg.sv | 13 +
 rtl/pulse_channel.sv | 129 ++++++++++++
 rtl/pulse_scheduler.sv | 87 ++++++++
 tb/tb_pulse_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pulse_scheduler_pkg.sv
// Purpose : shared defaults and FSM state encoding for the pulse scheduler.
// Contents: NCH_DEF / PW_DEF / DW_DEF parameter defaults and the per-channel
//           IDLE/RUN state constants.
package pulse_sched_pkg;

    localparam int NCH_DEF = 4;  // number of channels
    localparam int PW_DEF  = 8;  // pattern width per channel
    localparam int DW_DEF  = 4;  // step-divider width

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/pulse_channel.sv
// Purpose : one pulse channel. It holds the channel configuration and a
//           two-state FSM, and serialises the pattern LSB-first with each
//           bit held div+1 clocks.
// Ports   : clock, reset_n       - clock, async active-low reset
//           cfg_wr_i             - accepted configuration write (decoded by top)
//           cfg_pattern_i/len_i/div_i/repeat_i - configuration fields
//           start_i, stop_i      - start / abort requests
//           signal_o             - registered pulse output
//           done_o               - one-cycle pulse on one-shot completion
//           state_o              - current FSM state (ST_IDLE / ST_RUN)
module pulse_channel
    import pulse_sched_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int DW = DW_DEF,
    localparam int LW = (PW > 1) ? $clog2(PW) : 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          cfg_wr_i,
    input  logic [PW-1:0] cfg_pattern_i,
    input  logic [LW-1:0] cfg_len_i,
    input  logic [DW-1:0] cfg_div_i,
    input  logic          cfg_repeat_i,
    input  logic          start_i,
    input  logic          stop_i,
    output logic          signal_o,
    output logic          done_o,
    output logic [0:0]    state_o
);

    logic [0:0]    state_q, state_d;
    logic [PW-1:0] pattern_q, pattern_d;
    logic [LW-1:0] len_q, len_d;
    logic [DW-1:0] div_q, div_d;
    logic          rpt_q, rpt_d;
    logic [LW-1:0] bit_q, bit_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          signal_q, signal_d;
    logic          done_q, done_d;

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        div_d     = div_q;
        rpt_d     = rpt_q;
        bit_d     = bit_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;

        // The top only asserts cfg_wr_i when this channel is IDLE and not
        // being started, so a write can never disturb a running sequence.
        if (cfg_wr_i) begin
            pattern_d = cfg_pattern_i;
            len_d     = cfg_len_i;
            div_d     = cfg_div_i;
            rpt_d     = cfg_repeat_i;
        end

        case (state_q)
            ST_IDLE: begin
                // stop has priority over a simultaneous start
                if (start_i && !stop_i) begin
                    state_d = ST_RUN;
                    bit_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                    bit_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == div_q) begin
                    cnt_d = '0;
                    if (bit_q == len_q) begin
                        bit_d = '0;
                        if (!rpt_q) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + LW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                bit_d   = '0;
                cnt_d   = '0;
            end
        endcase

        // Output is registered: it shows the bit selected for the next cycle.
        signal_d = (state_d == ST_RUN) ? pattern_q[bit_d] : 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            pattern_q <= '0;
            len_q     <= '0;
            div_q     <= '0;
            rpt_q     <= 1'b0;
            bit_q     <= '0;
            cnt_q     <= '0;
            signal_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            div_q     <= div_d;
            rpt_q     <= rpt_d;
            bit_q     <= bit_d;
            cnt_q     <= cnt_d;
            signal_q  <= signal_d;
            done_q    <= done_d;
        end
    end

    assign signal_o = signal_q;
    assign done_o   = done_q;
    assign state_o  = state_q;

endmodule

// File: rtl/pulse_scheduler.sv
// Purpose : NCH independent pattern pulse generators sharing one
//           configuration write port.
// Ports   : clock, reset_n   - clock, async active-low reset
//           cfg_we, cfg_ch   - write strobe and target channel
//           cfg_pattern/len/div/repeat - channel configuration fields
//           cfg_err          - one-cycle pulse when a write is rejected
//           start, stop      - per-channel start / abort requests
//           signal, busy, done - per-channel registered outputs
// Handshake: none; a write is accepted in the cycle cfg_we is high unless
//           the target is out of range, RUNning, or being started that cycle.
module pulse_scheduler
    import pulse_sched_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int PW  = PW_DEF,
    parameter int DW  = DW_DEF,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int LW = (PW > 1) ? $clog2(PW) : 1
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           cfg_we,
    input  logic [CW-1:0]  cfg_ch,
    input  logic [PW-1:0]  cfg_pattern,
    input  logic [LW-1:0]  cfg_len,
    input  logic [DW-1:0]  cfg_div,
    input  logic           cfg_repeat,
    output logic           cfg_err,
    input  logic [NCH-1:0] start,
    input  logic [NCH-1:0] stop,
    output logic [NCH-1:0] signal,
    output logic [NCH-1:0] busy,
    output logic [NCH-1:0] done
);

    logic [NCH-1:0] sel;        // one-hot decode of cfg_ch (zero if out of range)
    logic [NCH-1:0] wr_ok;      // accepted write per channel
    logic [NCH-1:0] run_w;
    logic           reject;
    logic           cfg_err_q, cfg_err_d;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NCH; i++) begin
            sel[i] = cfg_we && (cfg_ch == CW'(i));
        end
        // Out of range shows up as no channel selected.
        reject    = cfg_we && ((sel == '0) || ((sel & (run_w | start)) != '0));
        wr_ok     = reject ? '0 : sel;
        cfg_err_d = reject;
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [0:0] st;

        pulse_channel #(.PW(PW), .DW(DW)) u_ch (
            .clock         (clock),
            .reset_n       (reset_n),
            .cfg_wr_i      (wr_ok[g]),
            .cfg_pattern_i (cfg_pattern),
            .cfg_len_i     (cfg_len),
            .cfg_div_i     (cfg_div),
            .cfg_repeat_i  (cfg_repeat),
            .start_i       (start[g]),
            .stop_i        (stop[g]),
            .signal_o      (signal[g]),
            .done_o        (done[g]),
            .state_o       (st)
        );

        // Direct decode of the registered state, so busy is registered too.
        assign run_w[g] = (st == ST_RUN);
    end

    assign busy = run_w;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed bench for pulse_scheduler with hand-computed expected values.
module tb_pulse_scheduler;

    logic       clock;
    logic       reset_n;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_pattern;
    logic [2:0] cfg_len;
    logic [3:0] cfg_div;
    logic       cfg_repeat;
    logic       cfg_err;
    logic [3:0] start;
    logic [3:0] stop;
    logic [3:0] signal;
    logic [3:0] busy;
    logic [3:0] done;

    int err_cnt = 0;
    int chk_cnt = 0;

    pulse_scheduler dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_div     (cfg_div),
        .cfg_repeat  (cfg_repeat),
        .cfg_err     (cfg_err),
        .start       (start),
        .stop        (stop),
        .signal      (signal),
        .busy        (busy),
        .done        (done)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance one edge; sample point is 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [7:0] pat,
                             input logic [2:0] len, input logic [3:0] div,
                             input logic rpt);
        cfg_ch      = ch;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_div     = div;
        cfg_repeat  = rpt;
        cfg_we      = 1'b1;
        tick();
        cfg_we      = 1'b0;
    endtask

    initial begin
        logic [7:0] pat0;
        logic [3:0] exp_sig;
        logic [3:0] exp_done;
        int         hi;

        reset_n = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_pattern = '0; cfg_len = '0;
        cfg_div = '0; cfg_repeat = 1'b0; start = '0; stop = '0;
        tick();
        tick();
        check("rst_signal", 32'(signal), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_cfg_err", 32'(cfg_err), 32'h0);
        reset_n = 1'b1;
        tick();

        // One-shot on ch0 with a rejected write in the middle of the run.
        pat0 = 8'b0010_1011;
        cfg_write(2'd0, pat0, 3'd5, 4'd3, 1'b0);
        check("ch0_cfg_ok", 32'(cfg_err), 32'h0);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int i = 0; i < 24; i++) begin
            check("ch0_sig", 32'(signal[0]), 32'(pat0[i/4]));
            check("ch0_busy", 32'(busy[0]), 32'h1);
            check("ch0_done_lo", 32'(done[0]), 32'h0);
            check("ch0_cfg_err", 32'(cfg_err), (i == 6) ? 32'h1 : 32'h0);
            if (i == 5) begin
                cfg_ch = 2'd0; cfg_pattern = 8'hFF; cfg_len = 3'd7;
                cfg_div = 4'd0; cfg_repeat = 1'b1; cfg_we = 1'b1;
            end else begin
                cfg_we = 1'b0;
            end
            tick();
        end
        check("ch0_end_sig", 32'(signal[0]), 32'h0);
        check("ch0_end_busy", 32'(busy[0]), 32'h0);
        check("ch0_done", 32'(done[0]), 32'h1);
        tick();
        check("ch0_done_1cyc", 32'(done[0]), 32'h0);

        // Continuous ch1, period 3, then stop.
        cfg_write(2'd1, 8'b0000_0101, 3'd2, 4'd0, 1'b1);
        check("ch1_cfg_ok", 32'(cfg_err), 32'h0);
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("ch1_sig", 32'(signal[1]), (i % 3 == 1) ? 32'h0 : 32'h1);
            check("ch1_busy", 32'(busy[1]), 32'h1);
            check("ch1_no_done", 32'(done[1]), 32'h0);
            tick();
        end
        stop[1] = 1'b1;
        tick();
        stop[1] = 1'b0;
        check("ch1_stop_sig", 32'(signal[1]), 32'h0);
        check("ch1_stop_busy", 32'(busy[1]), 32'h0);
        check("ch1_stop_done", 32'(done[1]), 32'h0);

        // start+stop together on ch2, then write colliding with start.
        start[2] = 1'b1; stop[2] = 1'b1;
        tick();
        start[2] = 1'b0; stop[2] = 1'b0;
        check("ch2_ss_busy", 32'(busy[2]), 32'h0);
        tick();
        check("ch2_ss_busy2", 32'(busy[2]), 32'h0);
        cfg_ch = 2'd2; cfg_pattern = 8'hFF; cfg_len = 3'd3; cfg_div = 4'd2;
        cfg_repeat = 1'b0; cfg_we = 1'b1; start[2] = 1'b1;
        tick();
        cfg_we = 1'b0; start[2] = 1'b0;
        check("ch2_wr_start_err", 32'(cfg_err), 32'h1);
        check("ch2_run_busy", 32'(busy[2]), 32'h1);
        check("ch2_run_sig", 32'(signal[2]), 32'h0);
        tick();
        check("ch2_err_1cyc", 32'(cfg_err), 32'h0);
        check("ch2_end_busy", 32'(busy[2]), 32'h0);
        check("ch2_end_done", 32'(done[2]), 32'h1);

        // Reset in the middle of ch0 and ch3 sequences.
        cfg_write(2'd3, 8'hFF, 3'd7, 4'd1, 1'b1);
        start = 4'b1001;
        tick();
        start = '0;
        tick();
        tick();
        check("mid_sig", 32'(signal), 32'h9);
        check("mid_busy", 32'(busy), 32'h9);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_sig", 32'(signal), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_done", 32'(done), 32'h0);
        check("async_rst_err", 32'(cfg_err), 32'h0);
        tick();
        reset_n = 1'b1;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        check("post_rst_sig", 32'(signal[0]), 32'h0);
        check("post_rst_busy", 32'(busy[0]), 32'h1);
        tick();
        check("post_rst_busy_end", 32'(busy[0]), 32'h0);
        check("post_rst_done", 32'(done[0]), 32'h1);
        check("post_rst_ch3", 32'(busy[3]), 32'h0);

        // All four channels together with div = channel index.
        for (int c = 0; c < 4; c++) begin
            cfg_write(2'(c), 8'hFF, 3'd1, 4'(c), 1'b0);
            check("all_cfg_ok", 32'(cfg_err), 32'h0);
        end
        start = 4'hF;
        tick();
        start = '0;
        for (int t = 0; t < 10; t++) begin
            exp_sig  = '0;
            exp_done = '0;
            for (int c = 0; c < 4; c++) begin
                hi = 2 * (c + 1);
                exp_sig[c]  = (t < hi);
                exp_done[c] = (t == hi);
            end
            check("all_sig", 32'(signal), 32'(exp_sig));
            check("all_busy", 32'(busy), 32'(exp_sig));
            check("all_done", 32'(done), 32'(exp_done));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
